// File: rtl/mcp3_sched016.sv
// mcp3_sched016: round-robin issue scheduler for 16 requesters.
// Each requester holds up to two pending requests. One winner is presented at a time and
// held until the downstream accepts it. Accepting re-arbitrates in the same cycle, so the
// scheduler can issue once per cycle.
// Optional feature: define MCP3_SCHED016_CREDIT_EN to gate grants on downstream credits.
// Without it, the credit gate always passes and credit_count / err_overflow[1] read 0.
module mcp3_sched016 #(
    parameter int unsigned CREDIT_INIT = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] req_set,
    input  logic        issue_ready,
    input  logic        credit_return,
    output logic        issue_valid,
    output logic [3:0]  issue_id,
    output logic [15:0] req_full,
    output logic [6:0]  credit_count,
    output logic [1:0]  err_overflow
);

    typedef enum logic {StIdle = 1'b0, StGrant = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [1:0]  count_q [16];
    logic [3:0]  last_winner_q;
    logic [3:0]  issue_id_q, issue_id_d;
    logic        armed_q;
    logic        req_ovf_q;

    logic [15:0] req_eff;
    logic        ret_eff;
    logic        accept;
    logic [15:0] acc_vec;
    logic [15:0] pend_mask;
    logic [15:0] post_mask;
    logic        credit_ok;
    logic        credit_ok_post;
    logic        idle_found, post_found;
    logic [3:0]  idle_idx, post_idx;

    // First set bit of mask searching upward from base+1, wrapping; MSB flags a hit.
    function automatic logic [4:0] rr_pick(input logic [15:0] mask, input logic [3:0] base);
        logic [4:0] res;
        logic [3:0] idx;
        res = 5'd0;
        for (int k = 1; k <= 16; k++) begin
            idx = base + 4'(k);
            if (mask[idx] && !res[4]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // The first edge after reset release must not record requests or credit returns.
    assign req_eff = armed_q ? req_set : 16'd0;
    assign ret_eff = armed_q & credit_return;

    assign accept  = (state_q == StGrant) & issue_ready;
    assign acc_vec = accept ? (16'd1 << issue_id_q) : 16'd0;

    // Pending masks before and after the current acceptance, plus the full flags.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            pend_mask[i] = (count_q[i] != 2'd0);
            post_mask[i] = (count_q[i] != 2'd0) && !(acc_vec[i] && (count_q[i] == 2'd1));
            req_full[i]  = (count_q[i] == 2'd2);
        end
    end

    assign {idle_found, idle_idx} = rr_pick(pend_mask, last_winner_q);
    // After acceptance the accepted id becomes last_winner, so search from it.
    assign {post_found, post_idx} = rr_pick(post_mask, issue_id_q);

`ifdef MCP3_SCHED016_CREDIT_EN
    logic [6:0] credit_q;
    logic       cred_ovf_q;

    assign credit_ok      = (credit_q != 7'd0);
    assign credit_ok_post = (credit_q > {6'd0, accept});

    // Credit counter: return adds, acceptance consumes, simultaneous pair cancels.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            credit_q   <= 7'(CREDIT_INIT);
            cred_ovf_q <= 1'b0;
        end else if (ret_eff && !accept) begin
            if (credit_q == 7'd64) begin
                cred_ovf_q <= 1'b1;
            end else begin
                credit_q <= credit_q + 7'd1;
            end
        end else if (accept && !ret_eff) begin
            credit_q <= credit_q - 7'd1;
        end
    end

    assign credit_count    = credit_q;
    assign err_overflow[1] = cred_ovf_q;
`else
    logic unused_credit;

    assign unused_credit   = ret_eff;
    assign credit_ok       = 1'b1;
    assign credit_ok_post  = 1'b1;
    assign credit_count    = 7'd0;
    assign err_overflow[1] = 1'b0;
`endif

    assign err_overflow[0] = req_ovf_q;

    // Per-requester saturating pending counts and the sticky request-overflow flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                count_q[i] <= 2'd0;
            end
            req_ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (req_eff[i] && !acc_vec[i]) begin
                    if (count_q[i] == 2'd2) begin
                        req_ovf_q <= 1'b1;
                    end else begin
                        count_q[i] <= count_q[i] + 2'd1;
                    end
                end else if (acc_vec[i] && !req_eff[i]) begin
                    count_q[i] <= count_q[i] - 2'd1;
                end
            end
        end
    end

    // State register with the presented id, arbitration pointer and post-reset arm flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            issue_id_q    <= 4'd0;
            last_winner_q <= 4'd15;
            armed_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            issue_id_q <= issue_id_d;
            armed_q    <= 1'b1;
            if (accept) begin
                last_winner_q <= issue_id_q;
            end
        end
    end

    // Next-state: grant from idle, or re-arbitrate on acceptance while enabled.
    always_comb begin
        state_d    = state_q;
        issue_id_d = issue_id_q;
        unique case (state_q)
            StIdle: begin
                if (enable && idle_found && credit_ok) begin
                    state_d    = StGrant;
                    issue_id_d = idle_idx;
                end
            end
            StGrant: begin
                if (accept) begin
                    if (enable && post_found && credit_ok_post) begin
                        issue_id_d = post_idx;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    // Outputs come straight from flops.
    always_comb begin
        issue_valid = (state_q == StGrant);
        issue_id    = issue_id_q;
    end

endmodule

// File: tb/tb_mcp3_sched016.sv
// Testbench for mcp3_sched016: three instances (CREDIT_INIT 8, 2, 0) share one stimulus
// stream and are each compared every cycle against a queue-free behavioural model.
module tb_mcp3_sched016;

`ifdef MCP3_SCHED016_CREDIT_EN
    localparam bit CreditEn = 1'b1;
`else
    localparam bit CreditEn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] req_set = 16'd0;
    logic        issue_ready = 1'b0;
    logic        credit_return = 1'b0;

    logic        iv   [3];
    logic [3:0]  iid  [3];
    logic [15:0] full [3];
    logic [6:0]  cc   [3];
    logic [1:0]  err  [3];

    int n_total = 0;
    int n_bad   = 0;

    // Model state
    int m_cnt    [3][16];
    int m_credit [3];
    bit m_valid  [3];
    int m_id     [3];
    int m_last   [3];
    bit m_err0   [3];
    bit m_err1   [3];
    bit m_fresh;

    always #5 clock = ~clock;

    mcp3_sched016 #(.CREDIT_INIT(8)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .req_set(req_set),
        .issue_ready(issue_ready), .credit_return(credit_return),
        .issue_valid(iv[0]), .issue_id(iid[0]), .req_full(full[0]),
        .credit_count(cc[0]), .err_overflow(err[0])
    );
    mcp3_sched016 #(.CREDIT_INIT(2)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .req_set(req_set),
        .issue_ready(issue_ready), .credit_return(credit_return),
        .issue_valid(iv[1]), .issue_id(iid[1]), .req_full(full[1]),
        .credit_count(cc[1]), .err_overflow(err[1])
    );
    mcp3_sched016 #(.CREDIT_INIT(0)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .enable(enable), .req_set(req_set),
        .issue_ready(issue_ready), .credit_return(credit_return),
        .issue_valid(iv[2]), .issue_id(iid[2]), .req_full(full[2]),
        .credit_count(cc[2]), .err_overflow(err[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int init_credit(input int d);
        if (!CreditEn) return 0;
        case (d)
            0:       return 8;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) m_cnt[d][i] = 0;
            m_credit[d] = init_credit(d);
            m_valid[d]  = 1'b0;
            m_id[d]     = 0;
            m_last[d]   = 15;
            m_err0[d]   = 1'b0;
            m_err1[d]   = 1'b0;
        end
        m_fresh = 1'b1;
    endtask

    // Round-robin: first requester after base (wrapping) with work left; skip loses one.
    function automatic int rr_pick(input int d, input int base, input int skip);
        for (int k = 1; k <= 16; k++) begin
            int j;
            int c;
            j = (base + k) % 16;
            c = m_cnt[d][j] - ((j == skip) ? 1 : 0);
            if (c > 0) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input int d, input logic [15:0] req, input bit rdy, input bit en,
                              input bit ret);
        bit acc;
        bit gate;
        int w;
        int old_id;
        int n;
        acc    = m_valid[d] && rdy;
        old_id = m_id[d];
        gate   = !CreditEn || (m_credit[d] - (acc ? 1 : 0)) > 0;
        if (!m_valid[d]) begin
            w = rr_pick(d, m_last[d], -1);
            if (en && w >= 0 && gate) begin
                m_valid[d] = 1'b1;
                m_id[d]    = w;
            end
        end else if (acc) begin
            m_last[d] = old_id;
            w = rr_pick(d, old_id, old_id);
            if (en && w >= 0 && gate) m_id[d] = w;
            else m_valid[d] = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            bit inc;
            bit dec;
            inc = req[i];
            dec = acc && (old_id == i);
            if (inc && !dec) begin
                if (m_cnt[d][i] == 2) m_err0[d] = 1'b1;
                else m_cnt[d][i]++;
            end else if (dec && !inc) begin
                m_cnt[d][i]--;
            end
        end
        if (CreditEn) begin
            n = m_credit[d] + (ret ? 1 : 0) - (acc ? 1 : 0);
            if (n > 64) begin
                n = 64;
                m_err1[d] = 1'b1;
            end
            m_credit[d] = n;
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 3; d++) begin
            logic [15:0] exp_full;
            for (int i = 0; i < 16; i++) exp_full[i] = (m_cnt[d][i] == 2);
            check_eq($sformatf("valid%0d", d), 32'(iv[d]), 32'(m_valid[d]));
            if (m_valid[d]) check_eq($sformatf("id%0d", d), 32'(iid[d]), 32'(m_id[d]));
            check_eq($sformatf("full%0d", d), 32'(full[d]), 32'(exp_full));
            check_eq($sformatf("credit%0d", d), 32'(cc[d]), 32'(m_credit[d]));
            check_eq($sformatf("err%0d", d), 32'(err[d]), 32'({m_err1[d], m_err0[d]}));
        end
    endtask

    task automatic cycle();
        logic [15:0] r;
        bit rt;
        @(posedge clock);
        r  = m_fresh ? 16'd0 : req_set;
        rt = m_fresh ? 1'b0 : credit_return;
        for (int d = 0; d < 3; d++) model_step(d, r, issue_ready, enable, rt);
        m_fresh = 1'b0;
        @(negedge clock);
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Called at a negedge; the first edge after release carries inputs that must be ignored.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        @(negedge clock);
        reset_n       = 1'b1;
        req_set       = 16'hffff;
        credit_return = 1'b1;
        cycle();
        req_set       = 16'd0;
        credit_return = 1'b0;
    endtask

    task automatic pulse(input logic [15:0] r);
        req_set = r;
        cycle();
        req_set = 16'd0;
    endtask

    initial begin
        @(negedge clock);
        enable      = 1'b1;
        issue_ready = 1'b1;
        do_reset();

        // Single request: grant two cycles later, one credit consumed.
        pulse(16'h0001);
        cycles(5);

        // Four requesters served back-to-back in round-robin order.
        do_reset();
        pulse(16'h8421);
        cycles(8);

        // Four pending with few credits, then one credit return.
        do_reset();
        pulse(16'h000f);
        cycles(8);
        credit_return = 1'b1;
        cycle();
        credit_return = 1'b0;
        cycles(8);

        // Stalled downstream while requester 3 keeps pulsing: overflow and full.
        do_reset();
        issue_ready = 1'b0;
        pulse(16'h0008);
        cycle();
        pulse(16'h0008);
        cycle();
        pulse(16'h0008);
        issue_ready = 1'b1;
        cycles(6);

        // Reset in the middle of a grant to requester 7, then 0 wins first.
        do_reset();
        issue_ready = 1'b0;
        pulse(16'h0080);
        cycles(3);
        do_reset();
        issue_ready = 1'b1;
        pulse(16'h0081);
        cycles(5);

        // Three requests; the zero-credit instance only issues without credit gating.
        do_reset();
        pulse(16'h0007);
        cycles(6);

        // Enable dropped while granting: finish current issue, then idle.
        do_reset();
        issue_ready = 1'b0;
        pulse(16'h0003);
        cycles(2);
        enable = 1'b0;
        cycle();
        issue_ready = 1'b1;
        cycles(4);
        enable = 1'b1;
        cycles(5);

        // Flood credit returns to saturate the counter.
        do_reset();
        credit_return = 1'b1;
        cycles(66);
        credit_return = 1'b0;
        cycle();

        // Randomised traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req_set       = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom & $urandom)
                                                        : 16'd0;
            issue_ready   = ($urandom_range(0, 9) < 7);
            enable        = ($urandom_range(0, 9) != 0);
            credit_return = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) do_reset();
            else cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mcp3_sched016.md
MCP3_SCHED016 -- requirements
Module: mcp3_sched016

Interface
REQ-001 SHALL have parameter CREDIT_INIT, default 8, the downstream credit count loaded at reset (legal range 0..64).
REQ-002 SHALL have port clock  input  1  the single clock; all flops rise on posedge clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  high permits new grants.
REQ-005 SHALL have port req_set  input  16  per-requester one-cycle request pulse; bit i = requester i.
REQ-006 SHALL have port issue_ready  input  1  downstream accepts the current issue.
REQ-007 SHALL have port credit_return  input  1  one-cycle pulse returning one downstream credit.
REQ-008 SHALL have port issue_valid  output  1  registered; an issue is presented.
REQ-009 SHALL have port issue_id  output  4  registered; winning requester index.
REQ-010 SHALL have port req_full  output  16  bit i high when requester i has 2 pending.
REQ-011 SHALL have port credit_count  output  7  current credit count.
REQ-012 SHALL have port err_overflow  output  2  sticky; bit0 = request overflow, bit1 = credit overflow.

Function
REQ-013 SHALL hold a 2-bit saturating pending count per requester (0..2); req_set[i] increments, acceptance of issue_id==i decrements.
REQ-014 SHALL, on same-cycle req_set[i] and acceptance of i, leave count i unchanged.
REQ-015 SHALL, on req_set[i] with count i = 2 and no same-cycle acceptance of i, hold the count at 2 and set err_overflow[0].
REQ-016 SHALL drive req_full[i] = (count i == 2) combinationally from the registered count.
REQ-017 SHALL implement FSM states IDLE (issue_valid=0) and GRANT (issue_valid=1).
REQ-018 SHALL, in IDLE, move to GRANT the next cycle when enable=1, some count>0, and the credit gate passes.
REQ-019 SHALL select the winner round-robin: search starts at last_winner+1 mod 16 and wraps; last_winner resets to 15, so requester 0 has first priority.
REQ-020 SHALL hold issue_valid and issue_id stable in GRANT until issue_ready=1. Acceptance is issue_valid & issue_ready.
REQ-021 SHALL, on acceptance, update last_winner to issue_id, decrement that count and consume one credit.
REQ-022 SHALL, on acceptance, re-arbitrate in the same cycle using post-acceptance counts and credits. It stays in GRANT with the new winner (back-to-back, 1 issue/cycle) if eligible, else goes to IDLE.
REQ-023 SHALL give latency of req_set at cycle N to issue_valid at cycle N+2 when IDLE and eligible.
REQ-024 SHALL, when enable deasserts in GRANT, complete the outstanding issue and go to IDLE on acceptance, without re-arbitrating.
REQ-025 SHALL let the same requester win again on acceptance only when no other requester has count>0.
REQ-026 SHALL, on same-cycle credit_return and acceptance, leave credit_count unchanged.
REQ-027 SHALL, on credit_return with credit_count = 64 and no consumption, hold 64 and set err_overflow[1].
REQ-028 SHALL clear err_overflow bits only on reset.

Reset
REQ-029 SHALL, on reset_n low, asynchronously set: FSM to IDLE, issue_valid 0, issue_id 0, all counts 0, req_full 0, last_winner 15, err_overflow 0, credit_count CREDIT_INIT.
REQ-030 SHALL, on reset mid-GRANT, drop issue_valid immediately and discard the outstanding issue (no count decrement recorded).
REQ-031 SHALL ignore req_set and credit_return in the first clock edge after reset_n deasserts.

Configuration
REQ-032 SHALL, with MCP3_SCHED016_CREDIT_EN defined, gate grants on credit_count>0 and maintain credit_count per REQ-021, REQ-026 and REQ-027.
REQ-033 SHALL, without MCP3_SCHED016_CREDIT_EN, treat the credit gate as always true, ignore credit_return, tie credit_count to 0 and tie err_overflow[1] to 0.

Verification
REQ-034 SHALL cover: credits 8, req_set=16'h0001 at cycle 0, issue_ready=1 -> issue_valid=1 with issue_id=0 at cycle 2 only; credit_count goes to 7.
REQ-035 SHALL cover: req_set=16'h8421 in one cycle, issue_ready=1 -> issue_id sequence 0,5,10,15 on consecutive cycles, then issue_valid=0.
REQ-036 SHALL cover: CREDIT_INIT=2, 4 requests pending -> 2 issues, then stall in IDLE; one credit_return -> exactly one more issue.
REQ-037 SHALL cover: issue_ready=0 for 5 cycles while req_set[3] pulses 3 times -> issue_id stable; req_full[3]=1 and err_overflow[0]=1.
REQ-038 SHALL cover: reset_n low for 1 cycle mid-GRANT with id=7 -> issue_valid=0 immediately, credit_count=CREDIT_INIT, next grant starts from requester 0.
REQ-039 SHALL cover: macro undefined, CREDIT_INIT=0, 3 requests -> 3 issues; credit_count stays 0.
